zoctalram_scheduler: RTL

Sequences the OctalRAM operator block. After reset it runs bring-up in order: IC reset, mode-register write, mode-register readback. It then shares the operator's sync write and sync read operations between two requesters: the IR frame writer and the readout path. It sits between the IRStore capture/readout logic and the operator, and is the only driver of the operator's op-code, address and data inputs.

---
 rtl/zoctalram_pkg.sv | 50 +++++
 rtl/zoctalram_rr_arb2.sv | 35 +++
 rtl/zoctalram_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/zoctalram_pkg.sv
// Shared constants, state encoding and bring-up helpers for the OctalRAM
// operator scheduler.
package zoctalram_pkg;

  localparam int DEF_TIMEOUT_CYC = 4096;

  // Op codes understood by the OctalRAM operator block.
  localparam logic [2:0] OP_IDLE    = 3'd0;
  localparam logic [2:0] OP_RST_IC  = 3'd1;
  localparam logic [2:0] OP_WR_MR   = 3'd2;
  localparam logic [2:0] OP_RD_MR   = 3'd3;
  localparam logic [2:0] OP_SYNC_WR = 3'd4;
  localparam logic [2:0] OP_SYNC_RD = 3'd5;

  typedef enum logic [2:0] {
    S_RST,
    S_WMR,
    S_RMR,
    S_IDLE,
    S_OP,
    S_GAP,
    S_FAULT
  } state_e;

  // Identifies a requester; also used as the round-robin "last granted" pointer.
  typedef enum logic {
    REQ_WR = 1'b0,
    REQ_RD = 1'b1
  } req_e;

  // Bring-up step that follows the given one (the last step hands over to idle).
  function automatic state_e boot_next(input state_e s);
    case (s)
      S_RST:   return S_WMR;
      S_WMR:   return S_RMR;
      default: return S_IDLE;
    endcase
  endfunction

  // Op code driven while sitting in a bring-up state; idle for anything else.
  function automatic logic [2:0] state_code(input state_e s);
    case (s)
      S_RST:   return OP_RST_IC;
      S_WMR:   return OP_WR_MR;
      S_RMR:   return OP_RD_MR;
      default: return OP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/zoctalram_rr_arb2.sv
// Two-way round-robin arbiter: write requester on bit 0, read requester on
// bit 1. On a tie the requester not granted last wins.
module zoctalram_rr_arb2
  import zoctalram_pkg::*;
(
  input  logic       iClk,
  input  logic       iRst_N,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output req_e       last
);

  // Grant decision: a single requester always wins, a tie goes to the other one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = (last == REQ_RD) ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

  // Pointer moves only when a grant is actually taken.
  always_ff @(posedge iClk or negedge iRst_N) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!iRst_N) begin
      last <= REQ_RD;
    end else if (advance && (grant != 2'b00)) begin
      last <= grant[1] ? REQ_RD : REQ_WR;
    end
  end

endmodule

// File: rtl/zoctalram_scheduler.sv
// OctalRAM operator sequencer: runs IC reset / MR write / MR readback after
// reset, then shares sync write and sync read between two requesters.
module zoctalram_scheduler
  import zoctalram_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        iClk,
  input  logic        iRst_N,
  output logic [2:0]  oOp_Code,
  input  logic        iOp_Done,
  output logic [31:0] oAddress,
  output logic [15:0] oData,
  input  logic [15:0] iData,
  input  logic        iWr_Req,
  input  logic [31:0] iWr_Addr,
  input  logic [15:0] iWr_Data,
  output logic        oWr_Ack,
  input  logic        iRd_Req,
  input  logic [31:0] iRd_Addr,
  output logic        oRd_Ack,
  output logic [15:0] oRd_Data,
  output logic        oInit_Done,
  output logic        oBusy,
  output logic        oErr
);

  localparam int             CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e             state_q, state_d;
  state_e             gap_next_q, gap_next_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_wr_q, op_wr_d;
  logic [2:0]         code_d;
  logic [31:0]        addr_d;
  logic [15:0]        data_d, rd_data_d;
  logic               wr_ack_d, rd_ack_d, init_d, err_d;
  logic [1:0]         grant;
  req_e               arb_last_unused;  // pointer is internal to the arbiter; the FSM only needs the grant
  logic               timed_out;

  zoctalram_rr_arb2 u_arb (
    .iClk    (iClk),
    .iRst_N  (iRst_N),
    .req     ({iRd_Req, iWr_Req}),
    .advance (state_q == S_IDLE),
    .grant   (grant),
    .last    (arb_last_unused)
  );

  // The counter holds (cycles the current code has been visible) - 1.
  assign timed_out = (cnt_q == TMO_LAST);
  assign oBusy     = (state_q != S_IDLE);

  // Next-state and next-output logic; outputs hold unless a transition changes them.
  always_comb begin
    state_d    = state_q;
    gap_next_d = gap_next_q;
    cnt_d      = cnt_q;
    op_wr_d    = op_wr_q;
    code_d     = oOp_Code;
    addr_d     = oAddress;
    data_d     = oData;
    rd_data_d  = oRd_Data;
    wr_ack_d   = 1'b0;
    rd_ack_d   = 1'b0;
    init_d     = oInit_Done;
    err_d      = oErr;

    case (state_q)
      S_RST, S_WMR, S_RMR: begin
        if ((state_q == S_RST) && (oOp_Code == OP_IDLE)) begin
          // First cycle out of reset: raise the IC-reset code, done cannot be pending yet.
          code_d = OP_RST_IC;
        end else if (iOp_Done) begin
          state_d    = S_GAP;
          gap_next_d = boot_next(state_q);
          code_d     = OP_IDLE;
        end else if (timed_out) begin
          err_d   = 1'b1;
          code_d  = OP_IDLE;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        // One code-0 cycle lets the operator's step counter return to zero.
        state_d = gap_next_q;
        cnt_d   = '0;
        code_d  = state_code(gap_next_q);
        if (gap_next_q == S_IDLE) begin
          init_d = 1'b1;
        end
      end

      S_IDLE: begin
        if (grant != 2'b00) begin
          state_d = S_OP;
          cnt_d   = '0;
          op_wr_d = grant[0];
          if (grant[0]) begin
            code_d = OP_SYNC_WR;
            addr_d = iWr_Addr;
            data_d = iWr_Data;
          end else begin
            code_d = OP_SYNC_RD;
            addr_d = iRd_Addr;
          end
        end
      end

      S_OP: begin
        if (iOp_Done || timed_out) begin
          // A timed-out op still acks so the requester is never left hanging.
          state_d    = S_GAP;
          gap_next_d = S_IDLE;
          code_d     = OP_IDLE;
          if (!iOp_Done) begin
            err_d = 1'b1;
          end
          if (op_wr_q) begin
            wr_ack_d = 1'b1;
          end else begin
            rd_ack_d  = 1'b1;
            rd_data_d = iOp_Done ? iData : 16'h0000;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FAULT: begin
        // Absorbing: only reset leaves this state.
      end

      default: begin
        state_d = S_FAULT;
        code_d  = OP_IDLE;
      end
    endcase
  end

  // State, timeout counter and registered outputs.
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      state_q    <= S_RST;
      gap_next_q <= S_IDLE;
      cnt_q      <= '0;
      op_wr_q    <= 1'b0;
      oOp_Code   <= OP_IDLE;
      oAddress   <= '0;
      oData      <= '0;
      oRd_Data   <= '0;
      oWr_Ack    <= 1'b0;
      oRd_Ack    <= 1'b0;
      oInit_Done <= 1'b0;
      oErr       <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_next_q <= gap_next_d;
      cnt_q      <= cnt_d;
      op_wr_q    <= op_wr_d;
      oOp_Code   <= code_d;
      oAddress   <= addr_d;
      oData      <= data_d;
      oRd_Data   <= rd_data_d;
      oWr_Ack    <= wr_ack_d;
      oRd_Ack    <= rd_ack_d;
      oInit_Done <= init_d;
      oErr       <= err_d;
    end
  end

endmodule
